// File: rtl/instr_fetch_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
// master: drives mem_req/mem_addr, receives mem_ack/mem_rdata. slave: the memory side.
interface instr_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns PC, reads instruction memory, loads IR, applies branches.
// Ports: clk, rst_f (sync, active-low), fetch_req/br_* from controller, mem bus (master),
// ir/opcode/mm/ir_valid to controller, pc, busy, halted, fetch_err status.
module instr_fetch #(
    parameter int          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int          TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_req,
    input  logic              br_valid,
    input  logic              br_sel,
    input  logic [15:0]       br_imm,
    instr_fetch_if.master     mem,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fetch_err
);
    // Branch immediate is extended to at least ADDR_W bits before truncation.
    localparam int EW = (ADDR_W > 16) ? ADDR_W : 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] tgt;
    logic [EW-1:0]     ext;
    logic [31:0]       ir_q, ir_d;
    logic              irv_q, irv_d;
    logic              req_q, req_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            req_q   <= 1'b0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            req_q   <= req_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_req) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_ack) begin
                    if (mem.mem_rdata[31:28] == 4'hF) state_d = S_HALT;
                    else                              state_d = S_IDLE;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    state_d = S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Branch target; with no branch the fetch uses the current PC.
    always_comb begin
        if (br_sel) ext = EW'(br_imm);
        else        ext = EW'($signed(br_imm));
        if (!br_valid)   tgt = pc_q;
        else if (br_sel) tgt = ext[ADDR_W-1:0];
        else             tgt = pc_q + ext[ADDR_W-1:0];
    end

    always_comb begin
        pc_d   = pc_q;
        addr_d = addr_q;
        ir_d   = ir_q;
        irv_d  = 1'b0;
        req_d  = req_q;
        halt_d = halt_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                pc_d = tgt;
                if (fetch_req) begin
                    req_d  = 1'b1;
                    addr_d = tgt;
                    cnt_d  = '0;
                end
            end
            S_WAIT: begin
                if (mem.mem_ack) begin
                    ir_d  = mem.mem_rdata;
                    pc_d  = pc_q + ADDR_W'(1);
                    irv_d = 1'b1;
                    req_d = 1'b0;
                    if (mem.mem_rdata[31:28] == 4'hF) halt_d = 1'b1;
                end else if (cnt_q == 8'(TIMEOUT)) begin
                    // Fault completion: hand the controller a noop.
                    ir_d  = '0;
                    irv_d = 1'b1;
                    err_d = 1'b1;
                    req_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign ir           = ir_q;
    assign opcode       = ir_q[31:28];
    assign mm           = ir_q[27:24];
    assign ir_valid     = irv_q;
    assign pc           = pc_q;
    assign busy         = (state_q != S_IDLE);
    assign halted       = halt_q;
    assign fetch_err    = err_q;
endmodule
